plab5_mcore_net_to_mem_resp_adapter: RTL

//  Core-side receiver for memory responses. Accepts a split (control/data) network message from the

---
 rtl/plab5_mcore_net_to_mem_resp_adapter_pkg.sv | 32 +++
 rtl/plab5_mcore_dom_queue2.sv | 71 +++++++
 rtl/plab5_mcore_net_to_mem_resp_adapter.sv | 86 ++++++++
 3 files changed

// File: rtl/plab5_mcore_net_to_mem_resp_adapter_pkg.sv
// Field widths and layout helpers for memory-response and network messages
// shared by the response adapter and its entry queue.
package plab5_mcore_net_to_mem_resp_adapter_pkg;

   localparam int c_mem_resp_type_nbits = 3;

   typedef enum logic [c_mem_resp_type_nbits-1:0] {
      MEM_RESP_READ       = 3'd0,
      MEM_RESP_WRITE      = 3'd1,
      MEM_RESP_WRITE_INIT = 3'd2,
      MEM_RESP_AMO_ADD    = 3'd3,
      MEM_RESP_AMO_AND    = 3'd4,
      MEM_RESP_AMO_OR     = 3'd5
   } mem_resp_type_e;

   // Length field encodes the byte count of a full data word (0 means full width).
   function automatic int mem_resp_len_nbits(input int data_nbits);
      return $clog2(data_nbits / 8);
   endfunction

   // Memory response without its data word: {type, opaque, len}.
   function automatic int mem_resp_ctrl_nbits(input int opaque_nbits, input int data_nbits);
      return c_mem_resp_type_nbits + opaque_nbits + mem_resp_len_nbits(data_nbits);
   endfunction

   // Network message: {dest, src, net opaque, payload}.
   function automatic int net_msg_nbits(input int payload_nbits, input int opaque_nbits,
                                        input int srcdest_nbits);
      return 2 * srcdest_nbits + opaque_nbits + payload_nbits;
   endfunction

endpackage

// File: rtl/plab5_mcore_dom_queue2.sv
// Two-entry circular queue of {control, data, domain tag} with val/rdy on
// both sides; a full queue refuses enqueue even when a dequeue is pending.
module plab5_mcore_dom_queue2
   import plab5_mcore_net_to_mem_resp_adapter_pkg::*;
#(
   parameter int p_ctrl_nbits = 13,
   parameter int p_data_nbits = 32
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enq_val,
   output logic                    enq_rdy,
   input  logic [p_ctrl_nbits-1:0] enq_ctrl,
   input  logic [p_data_nbits-1:0] enq_data,
   input  logic                    enq_tag,
   output logic                    deq_val,
   input  logic                    deq_rdy,
   output logic [p_ctrl_nbits-1:0] deq_ctrl,
   output logic [p_data_nbits-1:0] deq_data,
   output logic                    deq_tag
);

   logic [1:0] count_reg;
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;

   logic [p_ctrl_nbits-1:0] ctrl_mem [0:1];
   logic [p_data_nbits-1:0] data_mem [0:1];
   logic                    tag_mem  [0:1];

   logic enq_fire;
   logic deq_fire;

   assign enq_rdy  = (count_reg < 2'd2);
   assign deq_val  = (count_reg != 2'd0);
   assign enq_fire = enq_val && enq_rdy;
   assign deq_fire = deq_val && deq_rdy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (enq_fire) wr_ptr_reg <= ~wr_ptr_reg;
         if (deq_fire) rd_ptr_reg <= ~rd_ptr_reg;
         if (enq_fire && !deq_fire)
            count_reg <= count_reg + 2'd1;
         else if (deq_fire && !enq_fire)
            count_reg <= count_reg - 2'd1;
      end
   end

   // Storage needs no reset: count gates visibility of every entry.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (enq_fire && (wr_ptr_reg == 1'(gi))) begin
               ctrl_mem[gi] <= enq_ctrl;
               data_mem[gi] <= enq_data;
               tag_mem[gi]  <= enq_tag;
            end
         end
      end
   endgenerate

   assign deq_ctrl = ctrl_mem[rd_ptr_reg];
   assign deq_data = data_mem[rd_ptr_reg];
   assign deq_tag  = tag_mem[rd_ptr_reg];

endmodule

// File: rtl/plab5_mcore_net_to_mem_resp_adapter.sv
// Core-side memory response receiver: drops misrouted network messages,
// strips the network header, queues responses and scrubs cross-domain data.
module plab5_mcore_net_to_mem_resp_adapter
   import plab5_mcore_net_to_mem_resp_adapter_pkg::*;
#(
   parameter int p_net_dest          = 0,
   parameter int p_num_ports         = 4,
   parameter int p_mem_opaque_nbits  = 8,
   parameter int p_mem_data_nbits    = 32,
   parameter int p_net_opaque_nbits  = 4,
   parameter int p_net_srcdest_nbits = 3,
   localparam int c_mc = mem_resp_ctrl_nbits(p_mem_opaque_nbits, p_mem_data_nbits),
   localparam int c_nc = net_msg_nbits(c_mc, p_net_opaque_nbits, p_net_srcdest_nbits)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mode,
   input  logic                        domain,
   input  logic                        in_val,
   output logic                        in_rdy,
   input  logic [c_nc-1:0]             in_msg_control,
   input  logic [p_mem_data_nbits-1:0] in_msg_data,
   output logic                        out_val,
   input  logic                        out_rdy,
   output logic [c_mc-1:0]             out_msg_control,
   output logic [p_mem_data_nbits-1:0] out_msg_data,
   output logic                        out_domain,
   output logic                        err_misroute,
   output logic [7:0]                  err_count
);

   logic [p_net_srcdest_nbits-1:0] net_dest;
   logic                           dest_ok;
   logic                           misroute_fire;
   logic                           q_enq_val;
   logic [p_mem_data_nbits-1:0]    q_deq_data;
   logic                           err_misroute_reg;
   logic [7:0]                     err_count_reg;
   logic                           unused_net_hdr;

   assign net_dest = in_msg_control[c_nc-1 -: p_net_srcdest_nbits];
   assign dest_ok  = (32'(net_dest) == p_net_dest) && (32'(net_dest) < p_num_ports);

   // Net src/opaque carry nothing the cache needs once the message has arrived.
   assign unused_net_hdr = ^in_msg_control[c_nc-p_net_srcdest_nbits-1:c_mc];

   // Misrouted messages are still consumed so they cannot wedge the network.
   assign q_enq_val     = in_val && dest_ok;
   assign misroute_fire = in_val && in_rdy && !dest_ok;

   plab5_mcore_dom_queue2 #(
      .p_ctrl_nbits (c_mc),
      .p_data_nbits (p_mem_data_nbits)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (q_enq_val),
      .enq_rdy  (in_rdy),
      .enq_ctrl (in_msg_control[c_mc-1:0]),
      .enq_data (in_msg_data),
      .enq_tag  (domain),
      .deq_val  (out_val),
      .deq_rdy  (out_rdy),
      .deq_ctrl (out_msg_control),
      .deq_data (q_deq_data),
      .deq_tag  (out_domain)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_misroute_reg <= 1'b0;
         err_count_reg    <= 8'd0;
      end else begin
         err_misroute_reg <= misroute_fire;
         if (misroute_fire && (err_count_reg != 8'hFF))
            err_count_reg <= err_count_reg + 8'd1;
      end
   end

   assign err_misroute = err_misroute_reg;
   assign err_count    = err_count_reg;

   // In secure mode a consumer only sees data tagged with its own domain.
   assign out_msg_data = (mode && (out_domain != domain)) ? '0 : q_deq_data;

endmodule
